bist_engine: RTL

Parametrised BIST engine that replaces the fixed 4-request, 8/16-bit controller + LFSR + MISR set with a single block. It wraps any external CUT with N_IN inputs, N_OUT outputs and one scan chain. It generates pseudo-random patterns and compresses the CUT outputs, followed by a scan-unload phase. It compares the result against a golden signature and reports pass/fail. It sits between the top-level functional inputs and the CUT.

---
 rtl/bist_engine.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bist_engine.sv
// Parametrised BIST engine: LFSR pattern source, MISR compactor, scan unload.
// Define BIST_SIG_OUT_EN to expose the raw MISR as signature_out.
module bist_engine #(
  parameter int N_IN = 4,
  parameter int N_OUT = 4,
  parameter int LFSR_BITS = 16,
  parameter logic [LFSR_BITS-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_BITS-1:0] LFSR_SEED = 16'h0001,
  parameter int MISR_BITS = 16,
  parameter logic [MISR_BITS-1:0] MISR_TAPS = 16'h1021,
  parameter int PATTERN_COUNT = 256,
  parameter int SCAN_LEN = 8,
  parameter logic [MISR_BITS-1:0] SIGNATURE_VALID = 16'h0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bist_start,
  input  logic [N_IN-1:0]  func_in,
  output logic [N_IN-1:0]  cut_in,
  output logic             cut_reset,
  output logic             cut_scan_en,
  output logic             cut_scan_in,
  input  logic [N_OUT-1:0] cut_out,
  input  logic             cut_scan_out,
  output logic             running,
  output logic             bist_end,
  output logic             pass_fail
`ifdef BIST_SIG_OUT_EN
  ,
  output logic [MISR_BITS-1:0] signature_out
`endif
);

  localparam int CMAX =
    (PATTERN_COUNT > SCAN_LEN) ? PATTERN_COUNT : SCAN_LEN;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PATTERN_COUNT - 1);
  localparam logic [CW-1:0] S_LAST =
    CW'((SCAN_LEN > 0) ? SCAN_LEN - 1 : 0);
  // An all-zero seed would lock the LFSR, so it is forced to 1.
  localparam logic [LFSR_BITS-1:0] SEED =
    (LFSR_SEED == '0) ? LFSR_BITS'(1) : LFSR_SEED;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    SCAN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nx;
  logic [LFSR_BITS-1:0] lfsr;
  logic [LFSR_BITS-1:0] lfsr_nx;
  logic [MISR_BITS-1:0] misr;
  logic [MISR_BITS-1:0] misr_nx;
  logic [MISR_BITS-1:0] misr_d;
  logic [N_IN-1:0]      pat;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lfsr     <= SEED;
      misr     <= '0;
      pat      <= '0;
      bist_end <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      // First DONE cycle always flags; afterwards it follows the request.
      bist_end <= (state == DONE) && (bist_start || !bist_end);
      unique case (state)
        INIT: begin
          lfsr <= SEED;
          misr <= '0;
        end
        RUN: begin
          lfsr <= lfsr_nx;
          misr <= misr_nx;
          pat  <= lfsr[N_IN-1:0];
        end
        SCAN: begin
          lfsr <= lfsr_nx;
          misr <= misr_nx;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (bist_start) state_nx = INIT;
      end
      INIT: begin
        cnt_nx   = '0;
        state_nx = RUN;
      end
      RUN: begin
        if (cnt == P_LAST) begin
          cnt_nx   = '0;
          state_nx = (SCAN_LEN == 0) ? DONE : SCAN;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      SCAN: begin
        if (cnt == S_LAST) begin
          cnt_nx   = '0;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: begin
        if (!bist_start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    misr_d = '0;
    if (state == RUN) begin
      misr_d = MISR_BITS'(cut_out);
    end else if (state == SCAN) begin
      misr_d[0] = cut_scan_out;
    end
    lfsr_nx = {lfsr[LFSR_BITS-2:0], ^(lfsr & LFSR_TAPS)};
    misr_nx = {misr[MISR_BITS-2:0], 1'b0}
            ^ (misr[MISR_BITS-1] ? MISR_TAPS : '0)
            ^ misr_d;
  end

  always_comb begin
    cut_in = func_in;
    if (state == INIT || state == RUN) begin
      cut_in = lfsr[N_IN-1:0];
    end else if (state == SCAN) begin
      cut_in = pat;
    end
  end

  assign running     = (state == INIT) || (state == RUN) || (state == SCAN);
  assign cut_reset   = reset || (state == INIT);
  assign cut_scan_en = (state == SCAN);
  assign cut_scan_in = lfsr[LFSR_BITS-1];
  assign pass_fail   = bist_end && (misr == SIGNATURE_VALID);

`ifdef BIST_SIG_OUT_EN
  assign signature_out = misr;
`endif

endmodule
